// File: rtl/sad_if.sv
// sad_if: beat/result handshake bundle between a SAD producer and the sad_accumulator
interface sad_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int SUM_W = 14
) ();
  logic                   signed_mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [SUM_W-1:0]       sad_out;
  logic                   busy;
  modport master (
    output signed_mode, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, sad_out, busy
  );
  modport slave (
    input  signed_mode, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, sad_out, busy
  );
endinterface

// File: rtl/sad_accumulator.sv
// sad_accumulator: pipelined |a-b| over LANES pairs per beat, summed across BLOCK beats
module sad_accumulator #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int BLOCK = 16,
  parameter int SUM_W = 14
) (
  input logic  clk,
  input logic  rst,
  sad_if.slave bus
);
  localparam int CW = BLOCK > 1 ? $clog2(BLOCK) : 1;
  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_abs [LANES];
  logic [WIDTH-1:0] r_abs [LANES];
  logic             r_s1_v, r_s2_v, r_run;
  logic [SUM_W-1:0] r_acc, r_sad, w_sum;
  logic             w_acc, w_last, w_take, w_drained, w_in_ready, w_out_valid;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH:0] w_d;
    assign w_d = {bus.signed_mode & bus.in_a[i*WIDTH+WIDTH-1], bus.in_a[i*WIDTH+:WIDTH]}
               - {bus.signed_mode & bus.in_b[i*WIDTH+WIDTH-1], bus.in_b[i*WIDTH+:WIDTH]};
    assign w_abs[i] = w_d[WIDTH] ? WIDTH'(~w_d + 1'b1) : w_d[WIDTH-1:0];
  end
  assign w_acc     = bus.in_valid && w_in_ready;
  assign w_last    = r_cnt == CW'(BLOCK - 1);
  assign w_take    = w_out_valid && bus.out_ready;
  assign w_drained = r_s2_v && !r_s1_v;
  // lane sum of the registered abs-diffs feeding the accumulator
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) w_sum = w_sum + SUM_W'(r_abs[i]);
  end
  // next state and handshake outputs
  always_comb begin
    w_next      = r_state;
    w_in_ready  = (r_state == ACCUM) && r_run;
    w_out_valid = r_state == DONE;
    case (r_state)
      ACCUM:   w_next = (w_acc && w_last) ? DRAIN : ACCUM;
      DRAIN:   w_next = w_drained ? DONE : DRAIN;
      DONE:    w_next = bus.out_ready ? ACCUM : DONE;
      default: w_next = ACCUM;
    endcase
  end
  // state register; r_run keeps in_ready low until the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end
  // beat counter within the current block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (w_acc) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end
  // stage 1: capture per-lane absolute differences of an accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_abs  <= '{default: '0};
    end else begin
      r_s1_v <= w_acc;
      if (w_acc) r_abs <= w_abs;
    end
  end
  // stage 2: accumulate, cleared when the finished result is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_s2_v <= 1'b0;
    end else begin
      r_s2_v <= r_s1_v;
      r_acc  <= w_take ? '0 : r_s1_v ? r_acc + w_sum : r_acc;
    end
  end
  // result register, loaded once the pipeline has absorbed the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sad <= '0;
    else if (r_state == DRAIN && w_drained) r_sad <= r_acc;
  end
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sad_out   = r_sad;
  assign bus.busy      = (r_state != ACCUM) || (r_cnt != '0);
endmodule

// File: tb/tb_sad_accumulator.sv
// tb_sad_accumulator: directed checks of sad_accumulator, plus an 8-bit-result twin for wrap behaviour
module tb_sad_accumulator;
  logic        clk = 1'b0;
  logic        rst, sm, iv, ordy;
  logic [31:0] ia, ib;
  int          n_chk = 0, n_err = 0, exp_acc;
  always #5 clk = ~clk;
  sad_if #(.WIDTH(8), .LANES(4), .SUM_W(14)) bus ();
  sad_if #(.WIDTH(8), .LANES(4), .SUM_W(8))  bus8 ();
  assign bus.signed_mode  = sm;
  assign bus.in_valid     = iv;
  assign bus.in_a         = ia;
  assign bus.in_b         = ib;
  assign bus.out_ready    = ordy;
  assign bus8.signed_mode = sm;
  assign bus8.in_valid    = iv;
  assign bus8.in_a        = ia;
  assign bus8.in_b        = ib;
  assign bus8.out_ready   = ordy;
  sad_accumulator #(.WIDTH(8), .LANES(4), .BLOCK(16), .SUM_W(14)) dut (.clk(clk), .rst(rst), .bus(bus));
  sad_accumulator #(.WIDTH(8), .LANES(4), .BLOCK(16), .SUM_W(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int absd(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ea, eb, d;
    ea = s ? {{24{a[7]}}, a} : {24'd0, a};
    eb = s ? {{24{b[7]}}, b} : {24'd0, b};
    d  = ea - eb;
    return d < 0 ? -d : d;
  endfunction
  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    iv = 1'b1; ia = a; ib = b; sm = s;
    for (int k = 0; k < 50 && !bus.in_ready; k++) @(negedge clk);
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    for (int i = 0; i < 4; i++) exp_acc += absd(a[i*8+:8], b[i*8+:8], s);
  endtask
  task automatic block(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_acc = 0;
    for (int j = 0; j < 16; j++) begin
      beat({4{a}}, {4{b}}, s);
      if (j == 0) begin
        #1 check("busy_first", int'(bus.busy), 1);
      end
    end
  endtask
  task automatic finish(input string tag, input int exp, input int hold);
    @(negedge clk);
    iv = 1'b0;
    check({tag, "_ov_n1"}, int'(bus.out_valid), 0);
    check({tag, "_rdy_drain"}, int'(bus.in_ready), 0);
    @(negedge clk);
    check({tag, "_ov_n2"}, int'(bus.out_valid), 0);
    @(negedge clk);
    check({tag, "_ov"}, int'(bus.out_valid), 1);
    check({tag, "_sad"}, int'(bus.sad_out), exp % 16384);
    check({tag, "_sad8"}, int'(bus8.sad_out), exp % 256);
    check({tag, "_busy"}, int'(bus.busy), 1);
    for (int h = 0; h < hold; h++) begin
      iv = 1'b1; ia = $urandom; ib = $urandom;
      @(negedge clk);
      check({tag, "_hold_ov"}, int'(bus.out_valid), 1);
      check({tag, "_hold_sad"}, int'(bus.sad_out), exp % 16384);
      check({tag, "_hold_rdy"}, int'(bus.in_ready), 0);
    end
    iv = 1'b0; ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0;
    check({tag, "_ov_taken"}, int'(bus.out_valid), 0);
    check({tag, "_rdy_back"}, int'(bus.in_ready), 1);
    check({tag, "_busy_idle"}, int'(bus.busy), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; sm = 1'b0; iv = 1'b0; ordy = 1'b0; ia = '0; ib = '0; exp_acc = 0;
    repeat (2) @(negedge clk);
    check("rst_ov", int'(bus.out_valid), 0);
    check("rst_sad", int'(bus.sad_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_rdy", int'(bus.in_ready), 0);
    rst = 1'b0;
    #1 check("rdy_before_edge", int'(bus.in_ready), 0);
    @(negedge clk);
    check("rdy_after_edge", int'(bus.in_ready), 1);
    block(8'd25, 8'd231, 1'b0);
    finish("uns", 13184, 0);
    block(8'd25, 8'd231, 1'b1);
    finish("sgn", 3200, 0);
    block(8'h80, 8'h7F, 1'b1);
    finish("sgn_max", 16320, 0);
    block(8'd255, 8'd0, 1'b0);
    finish("wrap", 16320, 0);
    for (int r = 0; r < 2; r++) begin
      exp_acc = 0;
      for (int j = 0; j < 16; j++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          iv = 1'b0;
        end
        beat($urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      finish("rnd", exp_acc, 0);
    end
    block(8'd10, 8'd3, 1'b0);
    finish("bp", 448, 10);
    block(8'd77, 8'd77, 1'b1);
    finish("bp_next", 0, 0);
    exp_acc = 0;
    for (int j = 0; j < 7; j++) beat($urandom, $urandom, 1'b0);
    @(negedge clk);
    iv = 1'b0; rst = 1'b1;
    #1;
    check("mid_rst_ov", int'(bus.out_valid), 0);
    check("mid_rst_sad", int'(bus.sad_out), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_rdy", int'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    block(8'd10, 8'd3, 1'b0);
    finish("post_rst", 448, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_extra_ov", int'(bus.out_valid), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sad_accumulator.md
# sad_accumulator

Streaming sum-of-absolute-differences engine for the SAD datapath: accepts LANES pixel pairs per beat, forms |A−B| per lane in signed or unsigned two's-complement mode, and accumulates BLOCK beats into one SAD result. It replaces per-sample two's-complement negation in the block-matching path with a pipelined, back-pressured unit that feeds the minimum-SAD search logic.

## Interface
- WIDTH, 8, pixel/sample width in bits
- LANES, 4, pixel pairs per input beat
- BLOCK, 16, beats per SAD result (≥ 1)
- SUM_W, 14, result width; must be ≥ WIDTH + ceil(log2(BLOCK·LANES)) for exact results

Reset is asynchronous and active-high.

- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- signed_mode  in  1  1 = lanes are signed two's complement; 0 = unsigned; sampled with each accepted beat
- in_valid  in  1  beat present
- in_ready  out  1  unit can accept a beat
- in_a  in  LANES·WIDTH  lane i at bits [i·WIDTH +: WIDTH]
- in_b  in  LANES·WIDTH  same packing as in_a
- out_valid  out  1  sad_out holds a finished result
- out_ready  in  1  consumer takes result
- sad_out  out  SUM_W  sum of |a−b| over BLOCK·LANES pairs, unsigned
- busy  out  1  at least one beat of the current block accepted and result not yet consumed

## Operation
- Beat accepted when in_valid && in_ready at a rising edge.
- Per lane: extend a and b to WIDTH+1 bits (sign-extend if signed_mode, else zero-extend), d = a − b, |d| = d[WIDTH] ? (~d + 1) : d. |d| ≤ 2^WIDTH − 1 in both modes, held in WIDTH bits.
- Stage 1 (register): LANES abs-diffs and a stage-valid bit.
- Stage 2 (register): acc ← acc + Σ lanes; the sum truncates to SUM_W (modulo 2^SUM_W if SUM_W undersized; no saturation).
- FSM states:
  - ACCUM: in_ready = 1. Counts accepted beats 0..BLOCK−1. On acceptance of beat BLOCK−1 → DRAIN.
  - DRAIN: in_ready = 0. Waits until stage 1 and stage 2 have absorbed the last beat (exactly 2 cycles after its acceptance edge) → DONE; sad_out ← final acc, out_valid ← 1.
  - DONE: in_ready = 0, out_valid = 1, sad_out stable. On out_valid && out_ready: out_valid ← 0, acc ← 0, beat count ← 0 → ACCUM.
- First beat of a block adds to a zeroed acc; no stale carry-over between blocks.
- Bubbles (in_valid low) in ACCUM leave acc and count unchanged; result independent of gap pattern.
- signed_mode may change between beats; each beat uses its own sampled value.

## Timing
- Reset (async assert, any state): state = ACCUM, acc = 0, count = 0, pipeline valids = 0, out_valid = 0, sad_out = 0, busy = 0. in_ready = 0 while rst high, 1 from first edge after release.
- Reset mid-block or while out_valid high discards the partial/held result; no out_valid follows.
- Latency: last beat accepted at edge N → out_valid high after edge N+2; sad_out valid the same cycle.
- Throughput: one beat/cycle in ACCUM; per block BLOCK + 2 + (cycles out_ready low) + 1 handover cycle; minimum BLOCK+3 cycles per result.
- Back-pressure: sad_out and out_valid held unchanged while out_ready low; in_ready stays low; in_valid in DRAIN/DONE has no effect.
- out_ready asserted without out_valid: ignored.
- BLOCK = 1: every accepted beat goes straight to DRAIN.

## Test plan
- Unsigned, LANES=4, BLOCK=16, all lanes a=25, b=231 for 16 back-to-back beats -> out_valid 2 cycles after last accept, sad_out = 206·64 = 13184.
- Same data with signed_mode=1 (b = −25) -> sad_out = 50·64 = 3200; a=−128, b=127 all lanes -> 255·64 = 16320 (max, exact in 14 bits).
- Random bubbles on in_valid and random a/b, mixed signed_mode per beat -> sad_out matches reference model; in_ready low from last accept until result taken.
- Hold out_ready low 10 cycles at DONE -> sad_out/out_valid constant, in_ready 0, extra in_valid beats ignored; release -> next block starts with acc = 0 (second block of a=b gives sad_out = 0).
- Assert rst for 1 cycle after 7 beats, then feed a fresh 16-beat block of a=10, b=3 unsigned -> only one out_valid, sad_out = 7·64 = 448; all outputs 0 during reset.
- SUM_W=8 override, a=255, b=0 unsigned, 16 beats -> sad_out = (255·64) mod 256 = 192 (wrap, no saturation).
